// File: rtl/sdp_ram_pkg.sv
// sdp_ram_pkg: shared types and defaults for the sdp_ram_clr storage primitive.
package sdp_ram_pkg;

  localparam int unsigned DEFAULT_DEPTH = 8192;
  localparam int unsigned DEFAULT_WIDTH = 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } clr_state_e;

endpackage

// File: rtl/sdp_ram_core.sv
// sdp_ram_core: bare simple-dual-port array, registered read, no reset on storage.
module sdp_ram_core
  import sdp_ram_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sdp_ram_clr.sv
// sdp_ram_clr: simple-dual-port RAM with a hardware clear sweep.
// Optional macro SDP_RAM_CLR_WR_FIRST_EN selects write-first read-during-write
// via a registered bypass outside the array; default is read-first.
module sdp_ram_clr
  import sdp_ram_pkg::*;
#(
  parameter int unsigned      DEPTH   = DEFAULT_DEPTH,
  parameter int unsigned      WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned      ADDR_W  = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              wr_drop
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    SRC_CONST = 2'd0,
    SRC_CORE  = 2'd1,
    SRC_BYP   = 2'd2
  } rd_src_e;

  clr_state_e        state;
  logic [ADDR_W-1:0] clr_addr;
  rd_src_e           src_q;

  logic              busy_i;
  logic              waddr_ok;
  logic              raddr_ok;
  logic              wr_acc;
  logic              rd_acc;
  logic              byp_hit;
  logic              core_we;
  logic              core_re;
  logic [ADDR_W-1:0] core_waddr;
  logic [WIDTH-1:0]  core_wdata;
  logic [WIDTH-1:0]  core_rdata;

  assign busy_i   = (state == CLEAR);
  assign busy     = busy_i;
  assign waddr_ok = ({1'b0, waddr} < DEPTH_X);
  assign raddr_ok = ({1'b0, raddr} < DEPTH_X);
  assign wr_acc   = we & ~busy_i & waddr_ok;
  assign rd_acc   = re & ~busy_i;

`ifdef SDP_RAM_CLR_WR_FIRST_EN
  logic [WIDTH-1:0] byp_q;

  assign byp_hit = rd_acc & wr_acc & (waddr == raddr);

  always_ff @(posedge clk) begin
    if (byp_hit) begin
      byp_q <= wdata;
    end
  end
`else
  assign byp_hit = 1'b0;
`endif

  assign core_we    = busy_i | wr_acc;
  assign core_waddr = busy_i ? clr_addr : waddr;
  assign core_wdata = busy_i ? CLR_VAL : wdata;
  assign core_re    = rd_acc & raddr_ok & ~byp_hit;

  sdp_ram_core #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .waddr (core_waddr),
    .wdata (core_wdata),
    .re    (core_re),
    .raddr (raddr),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // The array has no reset, so rdata is selected from a reset-able source tag;
  // an unread cycle leaves the tag and the core register untouched, holding rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid  <= 1'b0;
      wr_drop <= 1'b0;
      src_q   <= SRC_CONST;
    end else begin
      rvalid  <= rd_acc;
      wr_drop <= busy_i & (we | re);
      if (rd_acc) begin
        if (byp_hit) begin
          src_q <= SRC_BYP;
        end else if (raddr_ok) begin
          src_q <= SRC_CORE;
        end else begin
          src_q <= SRC_CONST;
        end
      end
    end
  end

  always_comb begin
    rdata = CLR_VAL;
    case (src_q)
      SRC_CORE: rdata = core_rdata;
`ifdef SDP_RAM_CLR_WR_FIRST_EN
      SRC_BYP:  rdata = byp_q;
`endif
      default:  rdata = CLR_VAL;
    endcase
  end

endmodule

// File: tb/tb_sdp_ram_clr.sv
// tb_sdp_ram_clr: self-checking bench for sdp_ram_clr (DEPTH=16, WIDTH=8, CLR_VAL=8'hA5).
module tb_sdp_ram_clr;

  localparam int unsigned DEP = 16;
  localparam logic [7:0]  CV  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr_req = 1'b0;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic       re = 1'b0;
  logic [3:0] raddr = '0;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       wr_drop;

  sdp_ram_clr #(
    .DEPTH   (DEP),
    .WIDTH   (8),
    .CLR_VAL (CV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re      (re),
    .raddr   (raddr),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [3:0] wa;
    logic [7:0] wd;
    logic       re;
    logic [3:0] ra;
    logic [7:0] exp;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  model [DEP];
  int          left = 0;
  logic [7:0]  last_rd = CV;
  logic [7:0]  sb_q [$];
  vec_t        tbl [$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, predict from the model, advance, compare.
  task automatic cyc(input logic i_we, input logic [3:0] i_wa, input logic [7:0] i_wd,
                     input logic i_re, input logic [3:0] i_ra, input logic i_clr,
                     input logic has_exp, input logic [7:0] exp_rd);
    logic       busy_now;
    logic       exp_drop;
    logic [7:0] rd;
    we = i_we; waddr = i_wa; wdata = i_wd;
    re = i_re; raddr = i_ra; clr_req = i_clr;
    busy_now = (left > 0);
    exp_drop = busy_now && (i_we || i_re);
    if (!busy_now && i_re) begin
      if (has_exp) begin
        rd = exp_rd;
      end else begin
`ifdef SDP_RAM_CLR_WR_FIRST_EN
        rd = (i_we && i_wa == i_ra) ? i_wd : model[i_ra];
`else
        rd = model[i_ra];
`endif
      end
      sb_q.push_back(rd);
    end
    if (busy_now) begin
      model[DEP - left] = CV;
      left--;
    end else begin
      if (i_we) model[i_wa] = i_wd;
      if (i_clr) left = DEP;
    end
    @(posedge clk);
    #1;
    chk("busy", {7'd0, busy}, {7'd0, (left > 0)});
    chk("wr_drop", {7'd0, wr_drop}, {7'd0, exp_drop});
    if (sb_q.size() > 0) begin
      last_rd = sb_q.pop_front();
      chk("rvalid", {7'd0, rvalid}, 8'd1);
      chk("rdata", rdata, last_rd);
    end else begin
      chk("rvalid_idle", {7'd0, rvalid}, 8'd0);
      chk("rdata_hold", rdata, last_rd);
    end
  endtask

  task automatic idle();
    cyc(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdata"}, rdata, CV);
    chk({tag, "_rvalid"}, {7'd0, rvalid}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd1);
    chk({tag, "_wr_drop"}, {7'd0, wr_drop}, 8'd0);
  endtask

  // Counts sampled busy cycles until it falls; expects exactly DEP.
  task automatic count_busy(input string name, input logic mid_clr);
    int n;
    n = 0;
    while (busy && n < 100) begin
      if (n >= 2 && n <= 5)
        cyc(1'b1, 4'(n), 8'hC0, 1'b1, 4'(n), mid_clr && n == 8, 1'b0, 8'd0);
      else
        cyc(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, mid_clr && n == 8, 1'b0, 8'd0);
      n++;
    end
    chk(name, 8'(n), 8'(DEP));
  endtask

  task automatic read_all_clr(input string name);
    for (int a = 0; a < DEP; a++) begin
      cyc(1'b0, 4'd0, 8'd0, 1'b1, 4'(a), 1'b0, 1'b1, CV);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] raw_exp;
`ifdef SDP_RAM_CLR_WR_FIRST_EN
    raw_exp = 8'h11;
`else
    raw_exp = 8'h22;
`endif
    for (int a = 0; a < DEP; a++) tbl.push_back('{we:1'b0, wa:4'd0, wd:8'd0, re:1'b1, ra:4'(a), exp:CV});
    tbl.push_back('{we:1'b1, wa:4'd5, wd:8'h3C, re:1'b0, ra:4'd0, exp:8'h00});
    tbl.push_back('{we:1'b0, wa:4'd0, wd:8'h00, re:1'b1, ra:4'd5, exp:8'h3C});
    tbl.push_back('{we:1'b0, wa:4'd0, wd:8'h00, re:1'b0, ra:4'd5, exp:8'h00});
    tbl.push_back('{we:1'b1, wa:4'd7, wd:8'h22, re:1'b0, ra:4'd0, exp:8'h00});
    tbl.push_back('{we:1'b1, wa:4'd7, wd:8'h11, re:1'b1, ra:4'd7, exp:raw_exp});
    tbl.push_back('{we:1'b0, wa:4'd0, wd:8'h00, re:1'b1, ra:4'd7, exp:8'h11});
    tbl.push_back('{we:1'b1, wa:4'd0, wd:8'h5A, re:1'b1, ra:4'd15, exp:CV});
    tbl.push_back('{we:1'b0, wa:4'd0, wd:8'h00, re:1'b1, ra:4'd0, exp:8'h5A});
    tbl.push_back('{we:1'b0, wa:4'd0, wd:8'h00, re:1'b0, ra:4'd0, exp:8'h00});

    // power-on reset and initial sweep
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;
    left = DEP;
    count_busy("por_busy_len", 1'b0);

    // table of reads/writes
    foreach (tbl[i]) begin
      cyc(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, 1'b0, 1'b1, tbl[i].exp);
    end

    // fill with address value, then clear with write in the same cycle
    for (int a = 0; a < DEP; a++) cyc(1'b1, 4'(a), 8'(a), 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
    for (int a = 0; a < DEP; a++) cyc(1'b0, 4'd0, 8'd0, 1'b1, 4'(a), 1'b0, 1'b1, 8'(a));
    idle();
    cyc(1'b1, 4'd3, 8'h77, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0);
    count_busy("clr_busy_len", 1'b1);
    read_all_clr("after_clr");

    // reset during a sweep at clear address 9
    cyc(1'b1, 4'd12, 8'hEE, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
    cyc(1'b0, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1, 1'b0, 8'd0);
    for (int k = 0; k < 20 && left > 7; k++) begin
      if (left == 8) cyc(1'b1, 4'd1, 8'h99, 1'b0, 4'd0, 1'b0, 1'b0, 8'd0);
      else idle();
    end
    chk("pre_rst_drop", {7'd0, wr_drop}, 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("mid_rst_hold");
    rst_n = 1'b1;
    sb_q.delete();
    last_rd = CV;
    left = DEP;
    count_busy("rst_busy_len", 1'b0);
    read_all_clr("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
